// File: rtl/dmux.sv
// dmux: 1-to-2 demultiplexer with registered outputs and saturating per-route nonzero counters
module dmux #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    logic [WIDTH-1:0] a_d, b_d;
    logic [CNT_W-1:0] cnt_a_d, cnt_b_d, cnt_a_q, cnt_b_q;
    logic             hit;

    always_comb begin
        a_d = sel ? '0 : in;
        b_d = sel ? in : '0;
        hit = in != '0;
        cnt_a_d = clr ? '0 : (hit && !sel && cnt_a_q != '1) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
        cnt_b_d = clr ? '0 : (hit && sel && cnt_b_q != '1) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign a     = a_d;
    assign b     = b_d;
    assign cnt_a = cnt_a_q;
    assign cnt_b = cnt_b_q;
endmodule

// File: tb/tb_dmux.sv
// tb_dmux: random and directed checks of two dmux configurations against a behavioural model
module tb_dmux;
    logic       clk = 0, rst_n, clr, sel, in1;
    logic [7:0] in8;
    logic       a1, b1, aq1, bq1;
    logic [7:0] ca1, cb1;
    logic [7:0] a8, b8, aq8, bq8;
    logic [1:0] ca8, cb8;
    int total = 0, bad = 0;
    int m1a, m1b, m1ca, m1cb, m8a, m8b, m8ca, m8cb;

    always #5 clk = ~clk;

    dmux u1 (.clk(clk), .rst_n(rst_n), .clr(clr), .in(in1), .sel(sel),
             .a(a1), .b(b1), .a_q(aq1), .b_q(bq1), .cnt_a(ca1), .cnt_b(cb1));
    dmux #(.WIDTH(8), .CNT_W(2)) u8 (.clk(clk), .rst_n(rst_n), .clr(clr), .in(in8), .sel(sel),
             .a(a8), .b(b8), .a_q(aq8), .b_q(bq8), .cnt_a(ca8), .cnt_b(cb8));

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return v + 1 > mx ? mx : v + 1;
    endfunction

    // Reference: registered outputs are last edge's routing, counters count nonzero routed data
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1a = 0; m1b = 0; m1ca = 0; m1cb = 0;
            m8a = 0; m8b = 0; m8ca = 0; m8cb = 0;
        end else begin
            m1a = sel ? 0 : int'(in1);
            m1b = sel ? int'(in1) : 0;
            m8a = sel ? 0 : int'(in8);
            m8b = sel ? int'(in8) : 0;
            if (clr) begin
                m1ca = 0; m1cb = 0; m8ca = 0; m8cb = 0;
            end else begin
                if (in1 != 0 && !sel) m1ca = sat(m1ca, 255);
                if (in1 != 0 && sel)  m1cb = sat(m1cb, 255);
                if (in8 != 0 && !sel) m8ca = sat(m8ca, 3);
                if (in8 != 0 && sel)  m8cb = sat(m8cb, 3);
            end
        end
    end

    always @(negedge clk) begin
        chk("a1", a1, sel ? 0 : int'(in1));
        chk("b1", b1, sel ? int'(in1) : 0);
        chk("a8", a8, sel ? 0 : int'(in8));
        chk("b8", b8, sel ? int'(in8) : 0);
        chk("aq1", aq1, m1a);
        chk("bq1", bq1, m1b);
        chk("aq8", aq8, m8a);
        chk("bq8", bq8, m8b);
        chk("ca1", ca1, m1ca);
        chk("cb1", cb1, m1cb);
        chk("ca8", ca8, m8ca);
        chk("cb8", cb8, m8cb);
        chk("onehot8", int'(a8 != 0 && b8 != 0), 0);
        chk("onehotq8", int'(aq8 != 0 && bq8 != 0), 0);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0; clr = 0; sel = 0; in1 = 0; in8 = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            in1 = i[1]; sel = i[0];
            #10;
            chk("truth_a", a1, int'(i == 2));
            chk("truth_b", b1, int'(i == 3));
            #10;
        end
        chk("rst_aq", aq1, 0);
        chk("rst_ca", ca1, 0);
        step();
        rst_n = 1; in1 = 1; sel = 0; in8 = 8'h01;
        repeat (3) step();
        chk("lag_aq", aq1, 1);
        chk("cnt_a3", ca1, 3);
        sel = 1;
        chk("lag_hold", aq1, 1);
        repeat (2) step();
        chk("cnt_a", ca1, 3);
        chk("cnt_b", cb1, 2);
        chk("cnt8_a", ca8, 3);
        chk("cnt8_b", cb8, 2);
        chk("lag_bq", bq1, 1);
        chk("lag_aq0", aq1, 0);
        clr = 1; sel = 0;
        step();
        chk("clr_a", ca1, 0);
        chk("clr_b", cb1, 0);
        clr = 0; in8 = 8'h05;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("sat8", ca8, k > 3 ? 3 : k);
        end
        in1 = 1; sel = 0;
        step();
        #1 rst_n = 0;
        #1;
        chk("arst_aq", aq1, 0);
        chk("arst_bq", bq1, 0);
        chk("arst_ca", ca1, 0);
        chk("arst_cb", cb1, 0);
        chk("arst_a", a1, 1);
        step();
        rst_n = 1; in8 = 8'hA5;
        for (int k = 0; k < 8; k++) begin
            sel = k[0];
            #1;
            chk("tog_a", a8, k[0] ? 0 : 8'hA5);
            chk("tog_b", b8, k[0] ? 8'hA5 : 0);
            step();
        end
        for (int k = 0; k < 2000; k++) begin
            rst_n = $urandom_range(63) != 0;
            clr = $urandom_range(15) == 0;
            sel = $urandom_range(1);
            in1 = $urandom_range(1);
            in8 = $urandom_range(3) == 0 ? 8'h00 : 8'($urandom);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmux.md
DMUX -- requirements
Module: dmux

Interface
REQ-001 Parameter WIDTH, default 1: data width of in, a, b, a_q and b_q.
REQ-002 Parameter CNT_W, default 8: width of each route counter.
REQ-003 clk  input  1  Single clock; all sequential logic updates on the rising edge.
REQ-004 rst_n  input  1  Asynchronous, active-low reset.
REQ-005 in  input  WIDTH  Data to route.
REQ-006 sel  input  1  Route select: 0 routes to a, 1 routes to b.
REQ-007 a  output  WIDTH  Combinational channel-A output.
REQ-008 b  output  WIDTH  Combinational channel-B output.
REQ-009 a_q  output  WIDTH  Registered channel-A output.
REQ-010 b_q  output  WIDTH  Registered channel-B output.
REQ-011 cnt_a  output  CNT_W  Count of cycles in which sel=0 and in is nonzero.
REQ-012 cnt_b  output  CNT_W  Count of cycles in which sel=1 and in is nonzero.
REQ-013 clr  input  1  Synchronous clear of both counters; active-high.

Function
REQ-014 Outputs a and b SHALL be purely combinational: a = sel ? 0 : in; b = sel ? in : 0.
REQ-015 a and b SHALL be independent of clk and rst_n; they SHALL settle within one propagation delay of any change to in or sel.
REQ-016 The unselected channel SHALL always be driven to all-zeros, never to X or Z.
REQ-017 a_q and b_q SHALL equal a and b as sampled at the previous rising edge (1-cycle latency).
REQ-018 At most one of a/b SHALL be nonzero at any time; the same applies to a_q/b_q.
REQ-019 On each rising edge with in != 0, the counter of the selected channel SHALL increment by 1.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-021 When clr=1 at a rising edge, both counters SHALL load 0.
REQ-022 clr SHALL take priority over an increment in the same cycle.
REQ-023 A change of sel between edges SHALL affect only the combinational outputs until the next edge.
REQ-024 in=X or sel=X need not be handled; outputs are unspecified under X inputs.

Reset
REQ-025 While rst_n=0, a_q, b_q, cnt_a and cnt_b SHALL be 0, regardless of clk.
REQ-026 Reset assertion SHALL take effect immediately, without waiting for a clock edge.
REQ-027 The first update after rst_n deasserts SHALL occur at the first rising edge at which rst_n=1.
REQ-028 Reset asserted mid-operation SHALL clear the registered state and SHALL leave a and b following in and sel.

Verification
REQ-029 With WIDTH=1 and {in,sel} applied in order 00, 01, 10, 11, each held 20 time units -> (a,b) SHALL read (0,0), (0,0), (1,0), (0,1).
REQ-030 in=1, sel=0 held for 3 edges after reset, then sel=1 for 2 edges -> cnt_a=3, cnt_b=2; a_q/b_q SHALL lag a/b by exactly one cycle.
REQ-031 CNT_W=2, in=1, sel=0 held for 6 edges -> cnt_a SHALL stay at 3 after the third edge.
REQ-032 clr=1 in the same cycle as an increment condition -> cnt_a=0 and cnt_b=0 after that edge.
REQ-033 rst_n pulsed low between edges while a_q=1 -> a_q, b_q and both counters SHALL read 0 immediately; a SHALL remain 1 while in=1 and sel=0.
REQ-034 WIDTH=8, in=8'hA5, sel toggled every edge -> a and b SHALL alternate between 8'hA5 and 0 and SHALL never both be nonzero.
